// File: rtl/misc_sched.sv
// Round-robin scheduler sharing one combinational Misc datapath among NREQ requesters.
// Each transaction: arbitrate, drive operands, hold for SETTLE cycles, capture, respond.
module misc_sched #(
  parameter int NREQ   = 4,
  parameter int SETTLE = 1,
  parameter int IDW    = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   REQ_VALID,
  output logic [NREQ-1:0]   REQ_READY,
  input  logic [NREQ*8-1:0] REQ_A,
  input  logic [NREQ*4-1:0] REQ_B,
  input  logic [NREQ*8-1:0] REQ_C,
  output logic [7:0]        DP_A,
  output logic [3:0]        DP_B,
  output logic [7:0]        DP_C,
  input  logic [7:0]        DP_XOUT1,
  input  logic [7:0]        DP_XOUT2,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [IDW-1:0]    RSP_ID,
  output logic [7:0]        RSP_X1,
  output logic [7:0]        RSP_X2,
  output logic              BUSY,
  output logic [15:0]       DONE_CNT
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0]     CNT_INIT = 4'(SETTLE - 1);
  localparam logic [IDW-1:0] PTR_INIT = IDW'(NREQ - 1);

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] tag;
  logic [3:0]     cnt;
  logic [15:0]    done_cnt;
  logic [IDW-1:0] winner;
  logic           found;
  logic           accept;

  // Search starts one past the last grant so the previous winner ranks last.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NREQ;
      if (!found && REQ_VALID[idx]) begin
        winner = IDW'(idx);
        found  = 1'b1;
      end
    end
  end

  assign accept = (state == S_IDLE) && found;

  always_comb begin
    REQ_READY = '0;
    if (accept) REQ_READY[winner] = 1'b1;
  end

  assign BUSY     = (state != S_IDLE);
  assign DONE_CNT = done_cnt;

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every register samples
    // the values from before this edge, independent of statement order.
    if (RST) begin
      // NOTE: the datapath operand and response registers are reset too, so the
      // shared Misc instance never sees stale operands from an abandoned transaction.
      state     <= S_IDLE;
      ptr       <= PTR_INIT;
      tag       <= '0;
      cnt       <= '0;
      DP_A      <= '0;
      DP_B      <= '0;
      DP_C      <= '0;
      RSP_VALID <= 1'b0;
      RSP_ID    <= '0;
      RSP_X1    <= '0;
      RSP_X2    <= '0;
      done_cnt  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            DP_A  <= REQ_A[winner*8 +: 8];
            DP_B  <= REQ_B[winner*4 +: 4];
            DP_C  <= REQ_C[winner*8 +: 8];
            tag   <= winner;
            ptr   <= winner;
            cnt   <= CNT_INIT;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            RSP_X1    <= DP_XOUT1;
            RSP_X2    <= DP_XOUT2;
            RSP_ID    <= tag;
            RSP_VALID <= 1'b1;
            state     <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            done_cnt  <= done_cnt + 16'd1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_misc_sched.sv
// Directed bench for misc_sched: SETTLE=1 instance driven by a vector table and
// hand sequences, plus a SETTLE=4 instance for the long-hold corner cases.
module tb_misc_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // SETTLE=1 instance
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0, req_ready;
  logic [31:0] req_a = '0, req_c = '0;
  logic [15:0] req_b = '0;
  logic [7:0]  dp_a, dp_c, dp_x1, dp_x2, rsp_x1, rsp_x2;
  logic [3:0]  dp_b;
  logic        rsp_valid, rsp_ready = 1'b1, busy;
  logic [1:0]  rsp_id;
  logic [15:0] done_cnt;

  // SETTLE=4 instance
  logic        s4_rst = 1'b1;
  logic [3:0]  s4_req_valid = '0, s4_req_ready;
  logic [31:0] s4_req_a = '0, s4_req_c = '0;
  logic [15:0] s4_req_b = '0;
  logic [7:0]  s4_dp_a, s4_dp_c, s4_dp_x1, s4_dp_x2, s4_rsp_x1, s4_rsp_x2;
  logic [3:0]  s4_dp_b;
  logic        s4_rsp_valid, s4_rsp_ready = 1'b1, s4_busy;
  logic [1:0]  s4_rsp_id;
  logic [15:0] s4_done_cnt;

  // Stand-in datapath: x1 = a + c, x2 = a ^ {b,b}
  assign dp_x1    = dp_a + dp_c;
  assign dp_x2    = dp_a ^ {dp_b, dp_b};
  assign s4_dp_x1 = s4_dp_a + s4_dp_c;
  assign s4_dp_x2 = s4_dp_a ^ {s4_dp_b, s4_dp_b};

  misc_sched #(.NREQ(4), .SETTLE(1), .IDW(2)) dut1 (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_A(req_a), .REQ_B(req_b), .REQ_C(req_c),
    .DP_A(dp_a), .DP_B(dp_b), .DP_C(dp_c), .DP_XOUT1(dp_x1), .DP_XOUT2(dp_x2),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_ID(rsp_id),
    .RSP_X1(rsp_x1), .RSP_X2(rsp_x2), .BUSY(busy), .DONE_CNT(done_cnt)
  );

  misc_sched #(.NREQ(4), .SETTLE(4), .IDW(2)) dut4 (
    .CLK(clk), .RST(s4_rst), .REQ_VALID(s4_req_valid), .REQ_READY(s4_req_ready),
    .REQ_A(s4_req_a), .REQ_B(s4_req_b), .REQ_C(s4_req_c),
    .DP_A(s4_dp_a), .DP_B(s4_dp_b), .DP_C(s4_dp_c), .DP_XOUT1(s4_dp_x1), .DP_XOUT2(s4_dp_x2),
    .RSP_VALID(s4_rsp_valid), .RSP_READY(s4_rsp_ready), .RSP_ID(s4_rsp_id),
    .RSP_X1(s4_rsp_x1), .RSP_X2(s4_rsp_x2), .BUSY(s4_busy), .DONE_CNT(s4_done_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Operand sets; requester i occupies byte/nibble i.
  localparam logic [31:0] PA = 32'h40302010;
  localparam logic [15:0] PB = 16'h4321;
  localparam logic [31:0] PC = 32'h04030201;
  localparam logic [31:0] QA = 32'hFF807F00;
  localparam logic [15:0] QB = 16'hF80A;
  localparam logic [31:0] QC = 32'h018081FF;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] a;
    logic [15:0] b;
    logic [31:0] c;
    int          id;
    logic [7:0]  x1;
    logic [7:0]  x2;
  } vec_t;

  vec_t vecs[11];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One full transaction on dut1 with a hand-computed winner and results.
  task automatic run_txn(input string name, input logic [3:0] mask, input logic [31:0] a,
                         input logic [15:0] b, input logic [31:0] c, input int id,
                         input logic [7:0] x1, input logic [7:0] x2);
    int n;
    @(negedge clk);
    req_valid = mask; req_a = a; req_b = b; req_c = c; rsp_ready = 1'b1;
    #1;
    n = 0;
    while (req_ready == 4'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({name, "_grant"}, req_ready, 4'b1 << id);
    @(negedge clk);
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({name, "_id"}, {rsp_valid, rsp_id}, {1'b1, 2'(id)});
    check({name, "_x"}, {rsp_x1, rsp_x2}, {x1, x2});
    @(negedge clk);
  endtask

  initial begin
    int edges;
    int ng;
    logic [3:0] gr[5];
    int gc[5];

    vecs[0]  = '{4'b1111, PA, PB, PC, 0, 8'h11, 8'h01};
    vecs[1]  = '{4'b1111, PA, PB, PC, 1, 8'h22, 8'h02};
    vecs[2]  = '{4'b0001, PA, PB, PC, 0, 8'h11, 8'h01};
    vecs[3]  = '{4'b1000, QA, QB, QC, 3, 8'h00, 8'h00};
    vecs[4]  = '{4'b1010, QA, QB, QC, 1, 8'h00, 8'h7F};
    vecs[5]  = '{4'b1010, QA, QB, QC, 3, 8'h00, 8'h00};
    vecs[6]  = '{4'b0101, QA, QB, QC, 0, 8'hFF, 8'hAA};
    vecs[7]  = '{4'b0101, QA, QB, QC, 2, 8'h00, 8'h08};
    vecs[8]  = '{4'b0110, PA, PB, PC, 1, 8'h22, 8'h02};
    vecs[9]  = '{4'b1100, PA, PB, PC, 2, 8'h33, 8'h03};
    vecs[10] = '{4'b1111, PA, PB, PC, 3, 8'h44, 8'h04};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    s4_rst = 1'b0;
    #1;

    // Reset state
    check("rst_ctrl", {rsp_valid, busy, req_ready}, 6'b0);
    check("rst_dp", {dp_a, dp_b, dp_c}, 20'h0);
    check("rst_rsp", {rsp_id, rsp_x1, rsp_x2, done_cnt}, 34'h0);

    // Requester 1 alone, latency counted from the grant cycle
    @(negedge clk);
    req_valid = 4'b0010; req_a = 32'h00000A00; req_b = 16'h0030; req_c = 32'h00000500;
    rsp_ready = 1'b1;
    #1;
    check("s1_grant", req_ready, 4'b0010);
    edges = 0;
    while (edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) begin
        check("s1_wait", {req_ready, busy, dp_a, dp_b, dp_c}, {4'b0, 1'b1, 8'd10, 4'd3, 8'd5});
        req_valid = '0;
      end
      if (rsp_valid) break;
    end
    check("s1_latency", edges, 2);
    check("s1_rsp", {rsp_id, rsp_x1, rsp_x2}, {2'd1, 8'h0F, 8'h39});
    @(negedge clk);
    check("s1_done", {busy, done_cnt}, {1'b0, 16'd1});

    // All requesters held valid: grant order and spacing
    do_reset();
    req_valid = 4'hF; req_a = PA; req_b = PB; req_c = PC; rsp_ready = 1'b1;
    ng = 0;
    for (int i = 0; i < 5; i++) begin
      gr[i] = '0;
      gc[i] = 0;
    end
    for (int cyc = 0; cyc < 30 && ng < 5; cyc++) begin
      #1;
      if (req_ready != 4'b0) begin
        gr[ng] = req_ready;
        gc[ng] = cyc;
        ng++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    for (int i = 0; i < 5; i++) check($sformatf("rr_grant%0d", i), gr[i], 4'b1 << (i % 4));
    for (int i = 1; i < 5; i++) check($sformatf("rr_gap%0d", i), gc[i] - gc[i-1], 3);

    // Vector table from a fresh reset (pointer starts at NREQ-1)
    do_reset();
    for (int i = 0; i < 11; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].mask, vecs[i].a, vecs[i].b, vecs[i].c,
              vecs[i].id, vecs[i].x1, vecs[i].x2);

    // Response back-pressure: outputs frozen, no grants until after the handshake
    @(negedge clk);
    req_valid = 4'b0100; req_a = PA; req_b = PB; req_c = PC; rsp_ready = 1'b0;
    #1;
    check("stall_grant", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = 4'hF;
    edges = 0;
    while (!rsp_valid && edges < 10) begin
      @(negedge clk);
      edges++;
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d", i), {rsp_valid, rsp_id, rsp_x1, rsp_x2, req_ready, busy},
            {1'b1, 2'd2, 8'h33, 8'h03, 4'b0, 1'b1});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("stall_hs_cycle", req_ready, 4'b0);
    @(negedge clk);
    check("stall_next_grant", req_ready, 4'b1000);

    // Reset while the requester-3 transaction sits in WAIT
    @(negedge clk);
    check("rstw_busy", busy, 1'b1);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    check("rstw_state", {busy, rsp_valid, dp_a, dp_b, dp_c, done_cnt}, 38'h0);
    ng = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) ng++;
    end
    check("rstw_no_rsp", ng, 0);
    req_valid = 4'hF;
    #1;
    check("rstw_grant0", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    edges = 0;
    while (busy && edges < 10) begin
      @(negedge clk);
      edges++;
    end
    check("rstw_drain", {busy, done_cnt}, {1'b0, 16'd1});

    // Completion counter wrap
    force dut1.done_cnt = 16'hFFFF;
    @(negedge clk);
    release dut1.done_cnt;
    #1;
    check("wrap_preload", done_cnt, 16'hFFFF);
    run_txn("wrap", 4'b0010, PA, PB, PC, 1, 8'h22, 8'h02);
    check("wrap_cnt", done_cnt, 16'h0000);

    // SETTLE=4: operands held for four WAIT cycles, late operand change ignored
    @(negedge clk);
    s4_req_valid = 4'b0001; s4_req_a = 32'h0000005A; s4_req_b = 16'h0006; s4_req_c = 32'h00000021;
    s4_rsp_ready = 1'b1;
    #1;
    check("s4_grant", s4_req_ready, 4'b0001);
    edges = 0;
    while (edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) begin
        s4_req_valid = '0;
        s4_req_a = 32'h000000FF;
      end
      if (s4_rsp_valid) break;
      check($sformatf("s4_hold%0d", edges), {s4_dp_a, s4_dp_b, s4_dp_c, s4_busy},
            {8'h5A, 4'h6, 8'h21, 1'b1});
    end
    check("s4_latency", edges, 5);
    check("s4_rsp", {s4_rsp_id, s4_rsp_x1, s4_rsp_x2}, {2'd0, 8'h7B, 8'h3C});
    @(negedge clk);
    check("s4_done", {s4_busy, s4_done_cnt}, {1'b0, 16'd1});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
